// File: rtl/pos_mask_builder.sv
// Rebuilds a set-bit mask from a framed stream of bit positions into a one-entry output slot.
// Optional duplicate-position detection is compiled in with POS_MASK_DUP_DETECT_EN.
module pos_mask_builder #(
    parameter int unsigned MASK_W = 8,
    localparam int unsigned POS_W = $clog2(MASK_W)
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [POS_W-1:0]  in_pos,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MASK_W-1:0] out_mask,
    output logic [POS_W:0]    out_count,
    output logic              out_dup
);

    logic [MASK_W-1:0] r_acc;
    logic              r_valid;
    logic [MASK_W-1:0] r_mask;
    logic [POS_W:0]    r_count;

    logic [MASK_W-1:0] w_onehot;
    logic [MASK_W-1:0] w_frame;
    logic [POS_W:0]    w_count;
    logic              w_accept;
    logic              w_load;

    // Out-of-range positions decode to an all-zero one-hot, so they set no bit.
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (in_pos == POS_W'(i)) begin
                w_onehot[i] = 1'b1;
            end
        end
    end

    assign w_frame = r_acc | w_onehot;

    always_comb begin
        w_count = '0;
        for (int i = 0; i < MASK_W; i++) begin
            w_count = w_count + (POS_W + 1)'(w_frame[i]);
        end
    end

    assign in_ready = !in_last || !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_load   = w_accept && in_last;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_acc   <= '0;
            r_valid <= 1'b0;
            r_mask  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_acc <= in_last ? '0 : w_frame;
            end
            // A load in the same cycle as a drain keeps the slot full with no bubble.
            if (w_load) begin
                r_valid <= 1'b1;
                r_mask  <= w_frame;
                r_count <= w_count;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef POS_MASK_DUP_DETECT_EN
    logic r_dup_acc;
    logic r_dup;
    logic w_hit;

    assign w_hit = |(r_acc & w_onehot);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_dup_acc <= 1'b0;
            r_dup     <= 1'b0;
        end else if (w_accept) begin
            if (in_last) begin
                r_dup_acc <= 1'b0;
                r_dup     <= r_dup_acc | w_hit;
            end else begin
                r_dup_acc <= r_dup_acc | w_hit;
            end
        end
    end

    assign out_dup = r_dup;
`else
    assign out_dup = 1'b0;
`endif

    assign out_valid = r_valid;
    assign out_mask  = r_mask;
    assign out_count = r_count;

endmodule

// File: tb/tb_pos_mask_builder.sv
// Self-checking bench for pos_mask_builder: directed scenarios plus a randomized run
// checked against a frame-level reference model.
module tb_pos_mask_builder;

    localparam int unsigned MASK_W = 8;
    localparam int unsigned POS_W  = 3;
`ifdef POS_MASK_DUP_DETECT_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              areset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [POS_W-1:0]  in_pos = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [MASK_W-1:0] out_mask;
    logic [POS_W:0]    out_count;
    logic              out_dup;

    int checks = 0;
    int failures = 0;

    pos_mask_builder #(.MASK_W(MASK_W)) dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pos    (in_pos),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_count (out_count),
        .out_dup   (out_dup)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int pos, input logic last);
        in_valid = v;
        in_pos   = POS_W'(pos);
        in_last  = last;
        #1;
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        drive(1'b0, 0, 1'b1);
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_mask !== 8'h00) begin failures++; $display("FAIL reset_mask: got %h want 00", out_mask); end
        checks++; if (out_count !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", out_count); end
        checks++; if (out_dup !== 1'b0) begin failures++; $display("FAIL reset_dup: got %b want 0", out_dup); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        areset_n = 1'b1;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_multi_beat();
        out_ready = 1'b1;
        drive(1'b1, 0, 1'b0); tick();
        drive(1'b1, 3, 1'b0); tick();
        drive(1'b1, 7, 1'b1); tick();
        drive(1'b0, 0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL multi_valid: got %b want 1", out_valid); end
        checks++; if (out_mask !== 8'h89) begin failures++; $display("FAIL multi_mask: got %h want 89", out_mask); end
        checks++; if (out_count !== 4'd3) begin failures++; $display("FAIL multi_count: got %0d want 3", out_count); end
        checks++; if (out_dup !== 1'b0) begin failures++; $display("FAIL multi_dup: got %b want 0", out_dup); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL multi_drop: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(1'b1, 5, 1'b1); tick();
        checks++; if (out_valid !== 1'b1 || out_mask !== 8'h20 || out_count !== 4'd1) begin
            failures++; $display("FAIL b2b_first: got v=%b m=%h c=%0d want v=1 m=20 c=1", out_valid, out_mask, out_count);
        end
        drive(1'b1, 1, 1'b1);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
        tick();
        drive(1'b0, 0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_mask !== 8'h02 || out_count !== 4'd1) begin
            failures++; $display("FAIL b2b_second: got v=%b m=%h c=%0d want v=1 m=02 c=1", out_valid, out_mask, out_count);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drop: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 6, 1'b1); tick();
        checks++; if (out_valid !== 1'b1 || out_mask !== 8'h40) begin
            failures++; $display("FAIL bp_hold_a: got v=%b m=%h want v=1 m=40", out_valid, out_mask);
        end
        drive(1'b1, 2, 1'b0);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_nonlast_ready0: got %b want 1", in_ready); end
        tick();
        drive(1'b1, 4, 1'b0);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_nonlast_ready1: got %b want 1", in_ready); end
        tick();
        drive(1'b1, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready: got %b want 0", in_ready); end
            checks++; if (out_valid !== 1'b1 || out_mask !== 8'h40 || out_count !== 4'd1) begin
                failures++; $display("FAIL bp_stable: got v=%b m=%h c=%0d want v=1 m=40 c=1", out_valid, out_mask, out_count);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        drive(1'b0, 0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_mask !== 8'h15 || out_count !== 4'd3) begin
            failures++; $display("FAIL bp_frame_b: got v=%b m=%h c=%0d want v=1 m=15 c=3", out_valid, out_mask, out_count);
        end
        tick();
    endtask

    task automatic test_dup();
        out_ready = 1'b1;
        drive(1'b1, 2, 1'b0); tick();
        drive(1'b1, 2, 1'b1); tick();
        drive(1'b0, 0, 1'b0);
        checks++; if (out_mask !== 8'h04 || out_count !== 4'd1) begin
            failures++; $display("FAIL dup_last_mask: got m=%h c=%0d want m=04 c=1", out_mask, out_count);
        end
        checks++; if (out_dup !== DUP_EN) begin failures++; $display("FAIL dup_last_flag: got %b want %b", out_dup, DUP_EN); end
        drive(1'b1, 3, 1'b0); tick();
        drive(1'b1, 3, 1'b0); tick();
        drive(1'b1, 5, 1'b1); tick();
        drive(1'b0, 0, 1'b0);
        checks++; if (out_mask !== 8'h28 || out_dup !== DUP_EN) begin
            failures++; $display("FAIL dup_mid: got m=%h d=%b want m=28 d=%b", out_mask, out_dup, DUP_EN);
        end
        drive(1'b1, 1, 1'b1); tick();
        drive(1'b0, 0, 1'b0);
        checks++; if (out_mask !== 8'h02 || out_dup !== 1'b0) begin
            failures++; $display("FAIL dup_cleared: got m=%h d=%b want m=02 d=0", out_mask, out_dup);
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b1;
        drive(1'b1, 1, 1'b0); tick();
        drive(1'b1, 4, 1'b0); tick();
        drive(1'b0, 0, 1'b0);
        areset_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        areset_n = 1'b1;
        tick();
        drive(1'b1, 6, 1'b1); tick();
        drive(1'b0, 0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_mask !== 8'h40 || out_count !== 4'd1) begin
            failures++; $display("FAIL rst_mid_frame: got v=%b m=%h c=%0d want v=1 m=40 c=1", out_valid, out_mask, out_count);
        end
        // Reset while a full slot is stalled must discard it.
        out_ready = 1'b0;
        tick();
        areset_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0 || out_mask !== 8'h00) begin
            failures++; $display("FAIL rst_stall: got v=%b m=%h want v=0 m=00", out_valid, out_mask);
        end
        areset_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int  q[$];
        bit  m_valid = 1'b0;
        int  m_mask = 0;
        int  m_count = 0;
        bit  m_dup = 1'b0;
        bit  v, last, rdy, exp_ready, acc;
        int  pos;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v    = ($urandom_range(0, 3) != 0);
            pos  = $urandom_range(0, MASK_W - 1);
            last = ($urandom_range(0, 2) == 0);
            rdy  = ($urandom_range(0, 2) != 0);
            out_ready = rdy;
            drive(v, pos, last);
            exp_ready = !last || !m_valid || rdy;
            checks++; if (in_ready !== exp_ready) begin
                failures++; $display("FAIL rand_in_ready cyc=%0d: got %b want %b", cyc, in_ready, exp_ready);
            end
            acc = v && exp_ready;
            tick();
            if (acc) q.push_back(pos);
            if (acc && last) begin
                m_mask = 0;
                m_dup  = 1'b0;
                foreach (q[i]) begin
                    m_mask |= (1 << q[i]);
                    for (int j = 0; j < i; j++) if (q[j] == q[i]) m_dup = 1'b1;
                end
                m_count = $countones(m_mask);
                m_dup   = m_dup && DUP_EN;
                m_valid = 1'b1;
                q.delete();
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            checks++; if (out_valid !== m_valid) begin
                failures++; $display("FAIL rand_valid cyc=%0d: got %b want %b", cyc, out_valid, m_valid);
            end
            if (m_valid) begin
                checks++; if (out_mask !== MASK_W'(m_mask) || out_count !== (POS_W + 1)'(m_count) || out_dup !== m_dup) begin
                    failures++; $display("FAIL rand_data cyc=%0d: got m=%h c=%0d d=%b want m=%h c=%0d d=%b",
                                         cyc, out_mask, out_count, out_dup, m_mask[7:0], m_count, m_dup);
                end
            end
        end
        drive(1'b0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_multi_beat();
        test_back_to_back();
        test_backpressure();
        test_dup();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pos_mask_builder.md
# pos_mask_builder

Rebuilds an 8-bit set-bit mask from a stream of bit positions, one position per beat, framed by `in_last`. It is the inverse of the priority-position encoder: position streams produced by encoding logic are reassembled here into masks for downstream consumers. It has a valid/ready input, a single-entry registered output slot with valid/ready, and an optional duplicate-position detector.

## Interface

- `MASK_W`, default 8: output mask width. Localparam `POS_W = $clog2(MASK_W)`.
- `clk  in  1`: sole clock, rising edge.
- `areset_n  in  1`: asynchronous, active-low reset.
- `in_valid  in  1`: input beat valid.
- `in_ready  out  1`: input beat accepted when `in_valid && in_ready`.
- `in_pos  in  POS_W`: bit position to set.
- `in_last  in  1`: beat closes the current frame.
- `out_valid  out  1`: output slot holds a completed frame.
- `out_ready  in  1`: consumer takes the frame when `out_valid && out_ready`.
- `out_mask  out  MASK_W`: OR of one-hot(`in_pos`) over all beats of the frame.
- `out_count  out  POS_W+1`: popcount of `out_mask`.
- `out_dup  out  1`: the frame contained a repeated position. Driven only when the feature is compiled in (see Configuration).

## Operation

- Internal accumulator `acc[MASK_W]` and sticky `dup_acc`. Both are cleared by reset and after every accepted last beat.
- Accepted non-last beat:
  - `acc <= acc | onehot(in_pos)`.
  - `dup_acc <= dup_acc | acc[in_pos]`.
- Accepted last beat:
  - The output slot loads `acc | onehot(in_pos)`, its popcount, and `dup_acc | acc[in_pos]`.
  - `out_valid <= 1`, `acc <= 0`, `dup_acc <= 0`.
- `in_pos >= MASK_W` is only possible when `MASK_W` is not a power of 2. Such a beat contributes no bit and is not a duplicate, but it is still accepted and still honours `in_last`.
- `in_ready = !in_last || !out_valid || out_ready`:
  - Non-last beats are always accepted.
  - A last beat stalls while the output slot is occupied and not draining.
  - `in_ready` depends combinationally on `in_last`, `out_valid` and `out_ready`. It never depends on `in_valid`.
- Output drained (`out_valid && out_ready`) with no last beat accepted in the same cycle: `out_valid <= 0`.
- Simultaneous drain and last-beat accept: the new frame loads and `out_valid` stays 1 with no bubble.
- Every beat carries a position, so there are no empty frames.

## Timing

- Reset values: `out_valid=0`, `out_mask=0`, `out_count=0`, `out_dup=0`, `acc=0`, `dup_acc=0`. `in_ready` evaluates to 1 after reset.
- Latency: last beat accepted on edge N gives `out_valid`, `out_mask`, `out_count` and `out_dup` visible after edge N, i.e. valid in cycle N+1.
- Throughput: one beat per cycle. Back-to-back single-beat frames sustain one frame per cycle while `out_ready=1`.
- `out_mask`, `out_count` and `out_dup` are registered. They stay stable while `out_valid && !out_ready`.
- `areset_n` asserted mid-frame or mid-stall: the partial frame and the held output are discarded. The first frame after deassertion starts from `acc=0`.
- `out_count` range is 0..`MASK_W`. For `MASK_W=8` it is 4 bits and the maximum is 8.

## Configuration

- `POS_MASK_DUP_DETECT_EN` defined:
  - `dup_acc` logic is present.
  - `out_dup` reports whether any position repeated within the frame, including a repeat on the last beat.
- Not defined:
  - No `dup_acc` storage.
  - `out_dup` is tied to 0.
  - Mask, count, handshake and timing are identical to the defined case.

## Test plan

- Reset:
  - Hold `areset_n=0` -> all outputs 0 and `in_ready=1`.
  - Release reset with no input -> `out_valid` stays 0.
- Multi-beat frame:
  - Positions 0, 3, 7 with last on 7, `out_ready=1` -> cycle after last: `out_valid=1`, `out_mask=8'h89`, `out_count=4'd3`, `out_dup=0`.
  - `out_valid` drops to 0 the following cycle.
- Single-beat frames:
  - Back-to-back frames pos 5 then pos 1, `out_ready=1` -> consecutive cycles show `out_mask=8'h20` then `8'h02`, count 1 each, no bubble.
- Backpressure:
  - Frame A = {6}, `out_ready=0` -> output holds 8'h40.
  - Frame B non-last beats {2, 4} are accepted.
  - Frame B last beat 0 sees `in_ready=0` until `out_ready=1`. That cycle it is accepted; the next cycle shows `out_mask=8'h15`, count 3.
- Duplicate detection:
  - Positions 2, 2 (last) -> `out_mask=8'h04`, `out_count=1`.
  - `out_dup=1` with the macro defined, 0 without.
- Reset mid-frame:
  - Accept 1 and 4, pulse `areset_n` low, then send frame {6 last} -> `out_mask=8'h40`, count 1.
